// File: rtl/alarm_controller.sv
// Alarm controller: programmable alarm time, ringing with auto-timeout,
// bounded snooze and dismiss, all running off the 1 Hz clock.
module alarm_controller #(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned MAX_SNOOZE  = 3
) (
  input  logic       Clk_1sec,
  input  logic       reset,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  input  logic       set_en,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic       arm,
  input  logic       snooze,
  input  logic       dismiss,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic       ringing,
  output logic       snooze_active,
  output logic [1:0] snooze_count,
  output logic       set_err
);

  localparam int unsigned MAX_SECS = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int unsigned CW       = (MAX_SECS > 1) ? $clog2(MAX_SECS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] countdown;
  logic          set_valid;
  logic          match;

  assign set_valid = set_en && (set_hours <= 5'd23) && (set_minutes <= 6'd59);
  assign match     = (hours == alarm_hours) && (minutes == alarm_minutes) && (seconds == 6'd0);

  // Alarm-time registers, set error pulse and the alarm FSM share one register block
  always_ff @(posedge Clk_1sec) begin
    if (reset) begin
      state         <= IDLE;
      countdown     <= '0;
      alarm_hours   <= '0;
      alarm_minutes <= '0;
      ringing       <= 1'b0;
      snooze_active <= 1'b0;
      snooze_count  <= '0;
      set_err       <= 1'b0;
    end else begin
      set_err <= set_en && !set_valid;
      if (set_valid) begin
        alarm_hours   <= set_hours;
        alarm_minutes <= set_minutes;
      end

      if (!arm) begin
        state         <= IDLE;
        ringing       <= 1'b0;
        snooze_active <= 1'b0;
        snooze_count  <= '0;
      end else if (set_valid && (state == RINGING || state == SNOOZE)) begin
        // Re-programming the alarm abandons the current alarm event
        state         <= WAIT;
        ringing       <= 1'b0;
        snooze_active <= 1'b0;
        snooze_count  <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= WAIT;
          end
          WAIT: begin
            if (match) begin
              state     <= RINGING;
              ringing   <= 1'b1;
              countdown <= CW'(RING_SECS - 1);
            end
          end
          RINGING: begin
            if (dismiss) begin
              state        <= WAIT;
              ringing      <= 1'b0;
              snooze_count <= '0;
            end else if (snooze && (snooze_count < 2'(MAX_SNOOZE))) begin
              state         <= SNOOZE;
              ringing       <= 1'b0;
              snooze_active <= 1'b1;
              countdown     <= CW'(SNOOZE_SECS - 1);
              snooze_count  <= snooze_count + 2'd1;
            end else if (countdown == '0) begin
              state        <= WAIT;
              ringing      <= 1'b0;
              snooze_count <= '0;
            end else begin
              countdown <= countdown - CW'(1);
            end
          end
          SNOOZE: begin
            if (dismiss) begin
              state         <= WAIT;
              snooze_active <= 1'b0;
              snooze_count  <= '0;
            end else if (countdown == '0) begin
              state         <= RINGING;
              snooze_active <= 1'b0;
              ringing       <= 1'b1;
              countdown     <= CW'(RING_SECS - 1);
            end else begin
              countdown <= countdown - CW'(1);
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed self-checking bench for alarm_controller with default timing
// parameters (60 s ring, 300 s snooze, 3 snoozes).
module tb_alarm_controller;

  logic       Clk_1sec = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] seconds = '0;
  logic [5:0] minutes = '0;
  logic [4:0] hours = '0;
  logic       set_en = 1'b0;
  logic [4:0] set_hours = '0;
  logic [5:0] set_minutes = '0;
  logic       arm = 1'b0;
  logic       snooze = 1'b0;
  logic       dismiss = 1'b0;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       ringing;
  logic       snooze_active;
  logic [1:0] snooze_count;
  logic       set_err;

  int compared = 0;
  int mismatched = 0;

  alarm_controller dut (
    .Clk_1sec      (Clk_1sec),
    .reset         (reset),
    .seconds       (seconds),
    .minutes       (minutes),
    .hours         (hours),
    .set_en        (set_en),
    .set_hours     (set_hours),
    .set_minutes   (set_minutes),
    .arm           (arm),
    .snooze        (snooze),
    .dismiss       (dismiss),
    .alarm_hours   (alarm_hours),
    .alarm_minutes (alarm_minutes),
    .ringing       (ringing),
    .snooze_active (snooze_active),
    .snooze_count  (snooze_count),
    .set_err       (set_err)
  );

  always #5 Clk_1sec = ~Clk_1sec;

  // One clock edge; inputs were set beforehand, outputs settle by #1 after the edge
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk_1sec);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hours   = 5'(h);
    minutes = 6'(m);
    seconds = 6'(s);
  endtask

  task automatic chk_ind(input string tag, input int r, input int sa, input int sc);
    chk({tag, "_ringing"}, 32'(ringing), 32'(r));
    chk({tag, "_snooze_active"}, 32'(snooze_active), 32'(sa));
    chk({tag, "_snooze_count"}, 32'(snooze_count), 32'(sc));
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_alarm_hours", 32'(alarm_hours), 0);
    chk("rst_alarm_minutes", 32'(alarm_minutes), 0);
    chk("rst_set_err", 32'(set_err), 0);
    chk_ind("rst", 0, 0, 0);

    // Program 07:30
    set_en = 1'b1; set_hours = 5'd7; set_minutes = 6'd30;
    step();
    set_en = 1'b0;
    chk("set_hours", 32'(alarm_hours), 7);
    chk("set_minutes", 32'(alarm_minutes), 30);
    chk("set_ok_err", 32'(set_err), 0);

    // Arm and approach the alarm time
    arm = 1'b1;
    set_time(7, 29, 58); step();
    set_time(7, 29, 59); step();
    chk("pre_match_ringing", 32'(ringing), 0);
    set_time(7, 30, 0); step();
    chk("match_ringing", 32'(ringing), 1);
    set_time(7, 30, 1);
    step(59);
    chk("ring_last_cycle", 32'(ringing), 1);
    step();
    chk_ind("ring_timeout", 0, 0, 0);

    // Three snoozes, each lasting 300 cycles
    set_time(7, 30, 0); step();
    set_time(7, 30, 1);
    chk("retrigger_ringing", 32'(ringing), 1);
    for (int k = 1; k <= 3; k++) begin
      snooze = 1'b1; step(); snooze = 1'b0;
      chk_ind($sformatf("snooze%0d_start", k), 0, 1, k);
      step(299);
      chk($sformatf("snooze%0d_last", k), 32'(snooze_active), 1);
      step();
      chk_ind($sformatf("snooze%0d_end", k), 1, 0, k);
    end
    // Fourth snooze ignored; ringing runs to timeout
    snooze = 1'b1; step(); snooze = 1'b0;
    chk_ind("snooze4_ignored", 1, 0, 3);
    step(58);
    chk("snooze4_ring_last", 32'(ringing), 1);
    step();
    chk_ind("snooze4_timeout", 0, 0, 0);

    // Dismiss beats snooze on the same cycle
    set_time(7, 30, 0); step();
    set_time(7, 30, 1);
    dismiss = 1'b1; snooze = 1'b1; step();
    dismiss = 1'b0; snooze = 1'b0;
    chk_ind("dismiss_prio", 0, 0, 0);

    // Out-of-range set requests
    set_en = 1'b1; set_hours = 5'd24; set_minutes = 6'd10; step(); set_en = 1'b0;
    chk("bad_hours_err", 32'(set_err), 1);
    chk("bad_hours_keep_h", 32'(alarm_hours), 7);
    chk("bad_hours_keep_m", 32'(alarm_minutes), 30);
    step();
    chk("bad_hours_err_pulse", 32'(set_err), 0);
    set_en = 1'b1; set_hours = 5'd7; set_minutes = 6'd60; step(); set_en = 1'b0;
    chk("bad_min_err", 32'(set_err), 1);
    chk("bad_min_keep_m", 32'(alarm_minutes), 30);
    step();
    chk("bad_min_err_pulse", 32'(set_err), 0);

    // Disarm during snooze, then pass the alarm time disarmed
    set_time(7, 30, 0); step();
    set_time(7, 30, 1);
    snooze = 1'b1; step(); snooze = 1'b0;
    chk_ind("pre_disarm", 0, 1, 1);
    arm = 1'b0; step();
    chk_ind("disarm", 0, 0, 0);
    set_time(7, 30, 0); step();
    set_time(7, 30, 1); step();
    chk("disarmed_no_ring", 32'(ringing), 0);

    // Valid set during snooze abandons the event
    arm = 1'b1; step();
    set_time(7, 30, 0); step();
    set_time(7, 30, 1);
    snooze = 1'b1; step(); snooze = 1'b0;
    chk_ind("pre_reset_set", 0, 1, 1);
    set_en = 1'b1; set_hours = 5'd6; set_minutes = 6'd15; step(); set_en = 1'b0;
    chk_ind("set_in_snooze", 0, 0, 0);
    chk("set_in_snooze_h", 32'(alarm_hours), 6);
    chk("set_in_snooze_m", 32'(alarm_minutes), 15);

    // Reset while ringing, then alarm at midnight
    set_time(6, 15, 0); step();
    set_time(6, 15, 1);
    chk("ring_0615", 32'(ringing), 1);
    reset = 1'b1; step(); reset = 1'b0;
    chk_ind("reset_ringing", 0, 0, 0);
    chk("reset_alarm_h", 32'(alarm_hours), 0);
    chk("reset_alarm_m", 32'(alarm_minutes), 0);
    set_time(23, 59, 59); step();
    chk("pre_midnight", 32'(ringing), 0);
    set_time(0, 0, 0); step();
    chk("midnight_ring", 32'(ringing), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
